// File: rtl/pu_hop_rx.sv
// pu_hop_rx: collects one packet path of hop records into a local buffer and
// presents a completed-path descriptor that is held until the consumer releases it.
`default_nettype none

`ifndef HOP_INFO_NBITS
`define HOP_INFO_NBITS 16
`endif

module pu_hop_rx #(
  parameter int HOP_NBITS = `HOP_INFO_NBITS,
  parameter int MAX_HOPS  = 16,
  parameter int CNT_NBITS = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pp_pu_hop_valid,
  input  logic [HOP_NBITS-1:0]        pp_pu_hop_data,
  input  logic                        pp_pu_hop_sop,
  input  logic                        pp_pu_hop_eop,
  input  logic                        pp_pu_hop_error,
  output logic                        pu_pp_hop_ready,
  output logic                        pkt_valid,
  output logic [CNT_NBITS-1:0]        pkt_hop_count,
  output logic [1:0]                  pkt_status,
  input  logic                        pkt_done,
  input  logic [$clog2(MAX_HOPS)-1:0] hop_rd_addr,
  output logic [HOP_NBITS-1:0]        hop_rd_data,
  output logic [7:0]                  err_cnt
);

  localparam int AW = $clog2(MAX_HOPS);
  localparam logic [CNT_NBITS-1:0] FULL = CNT_NBITS'(MAX_HOPS);
  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_OVERFLOW = 2'd2;

  typedef enum logic [1:0] {IDLE, COLLECT, DROP, PEND} state_t;

  state_t               state, state_nxt;
  logic [CNT_NBITS-1:0] count, count_nxt;
  logic [1:0]           status, status_nxt;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [1:0]           err_inc;
  logic                 accept;
  logic [8:0]           err_sum;
  logic [HOP_NBITS-1:0] mem [MAX_HOPS];

  assign pu_pp_hop_ready = (state != PEND);
  assign accept          = pp_pu_hop_valid & pu_pp_hop_ready;
  assign pkt_valid       = (state == PEND);
  assign pkt_hop_count   = count;
  assign pkt_status      = status;

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    status_nxt = status;
    wr_en      = 1'b0;
    wr_addr    = count[AW-1:0];
    err_inc    = 2'd0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (pp_pu_hop_sop) begin
            wr_en      = 1'b1;
            wr_addr    = '0;
            count_nxt  = CNT_NBITS'(1);
            status_nxt = {1'b0, pp_pu_hop_eop & pp_pu_hop_error};
            state_nxt  = pp_pu_hop_eop ? PEND : COLLECT;
          end else begin
            err_inc = 2'd1;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          if (pp_pu_hop_sop) begin
            // A fresh sop abandons the partial path and restarts the buffer.
            wr_en      = 1'b1;
            wr_addr    = '0;
            count_nxt  = CNT_NBITS'(1);
            status_nxt = {1'b0, pp_pu_hop_eop & pp_pu_hop_error};
            state_nxt  = pp_pu_hop_eop ? PEND : COLLECT;
            err_inc    = 2'd1;
          end else if (count < FULL) begin
            wr_en     = 1'b1;
            count_nxt = count + CNT_NBITS'(1);
            if (pp_pu_hop_eop) begin
              status_nxt = {1'b0, pp_pu_hop_error};
              state_nxt  = PEND;
            end
          end else begin
            status_nxt = ST_OVERFLOW;
            state_nxt  = pp_pu_hop_eop ? PEND : DROP;
          end
        end
      end
      DROP: begin
        if (accept && pp_pu_hop_eop) begin
          status_nxt = ST_OVERFLOW;
          count_nxt  = FULL;
          state_nxt  = PEND;
        end
      end
      PEND: begin
        if (pkt_done) begin
          state_nxt  = IDLE;
          count_nxt  = '0;
          status_nxt = ST_OK;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state != PEND && state_nxt == PEND && status_nxt != ST_OK)
      err_inc = err_inc + 2'd1;
  end

  assign err_sum = {1'b0, err_cnt} + {7'd0, err_inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      status      <= ST_OK;
      err_cnt     <= 8'd0;
      hop_rd_data <= '0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      status      <= status_nxt;
      err_cnt     <= err_sum[8] ? 8'hFF : err_sum[7:0];
      hop_rd_data <= mem[hop_rd_addr];
    end
  end

  // Buffer has no reset; a same-address write/read returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= pp_pu_hop_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_pu_hop_rx.sv
// Randomized scoreboard bench for pu_hop_rx: a queue-based path model predicts
// descriptors; a consumer process reads them back and compares.
`default_nettype none

module tb_pu_hop_rx;

  localparam int HW   = 16;
  localparam int MAXH = 16;
  localparam int CW   = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hop_valid = 1'b0;
  logic [HW-1:0] hop_data = '0;
  logic          hop_sop = 1'b0, hop_eop = 1'b0, hop_error = 1'b0;
  logic          hop_ready;
  logic          pkt_valid;
  logic [CW-1:0] pkt_hop_count;
  logic [1:0]    pkt_status;
  logic          pkt_done = 1'b0;
  logic [3:0]    hop_rd_addr = '0;
  logic [HW-1:0] hop_rd_data;
  logic [7:0]    err_cnt;

  pu_hop_rx #(.HOP_NBITS(HW), .MAX_HOPS(MAXH), .CNT_NBITS(CW)) dut (
    .clk(clk), .rst(rst),
    .pp_pu_hop_valid(hop_valid), .pp_pu_hop_data(hop_data),
    .pp_pu_hop_sop(hop_sop), .pp_pu_hop_eop(hop_eop), .pp_pu_hop_error(hop_error),
    .pu_pp_hop_ready(hop_ready), .pkt_valid(pkt_valid),
    .pkt_hop_count(pkt_hop_count), .pkt_status(pkt_status), .pkt_done(pkt_done),
    .hop_rd_addr(hop_rd_addr), .hop_rd_data(hop_rd_data), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cnt;
    int          st;
    int          err;
    logic [15:0] hops [16];
  } desc_t;

  desc_t       exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_busy = 0;

  // Reference model: the current path is a plain list of hop words.
  bit          in_pkt = 0;
  bit          ovf = 0;
  logic [15:0] cur[$];
  int          merr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void bump();
    if (merr < 255) merr++;
  endfunction

  task automatic model_beat(input bit sop, input bit eop, input bit err, input logic [15:0] d);
    desc_t e;
    if (sop && !(in_pkt && ovf)) begin
      if (in_pkt) bump();
      cur.delete();
      cur.push_back(d);
      in_pkt = 1;
      ovf = 0;
    end else if (!in_pkt) begin
      bump();
      return;
    end else if (!ovf) begin
      if (cur.size() < MAXH) cur.push_back(d);
      else ovf = 1;
    end
    if (eop) begin
      e.cnt = cur.size();
      e.st  = ovf ? 2 : (err ? 1 : 0);
      if (e.st != 0) bump();
      e.err = merr;
      for (int i = 0; i < 16; i++) e.hops[i] = (i < cur.size()) ? cur[i] : 16'h0;
      exp_q.push_back(e);
      in_pkt = 0;
      ovf = 0;
    end
  endtask

  // Offer one beat from a negedge and hold it until accepted.
  task automatic send(input bit sop, input bit eop, input bit err, input logic [15:0] d);
    int t = 0;
    hop_valid = 1'b1; hop_sop = sop; hop_eop = eop; hop_error = err; hop_data = d;
    while (!hop_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!hop_ready) begin
      n_checks++; n_fail++;
      $display("FAIL ready_timeout: ready stayed %0b, required 1", hop_ready);
      hop_valid = 1'b0;
      return;
    end
    model_beat(sop, eop, err, d);
    @(negedge clk);
    hop_valid = 1'b0; hop_sop = 1'b0; hop_eop = 1'b0; hop_error = 1'b0;
  endtask

  task automatic send_pkt(input int len, input bit err, input int midsop);
    for (int i = 0; i < len; i++)
      send(i == 0 || i == midsop, i == len - 1,
           (i == len - 1) ? err : 1'($urandom), 16'($urandom));
  endtask

  // Consumer / monitor
  initial begin
    desc_t d;
    bit    have;
    forever begin
      @(negedge clk);
      if (rst || !pkt_valid) continue;
      mon_busy = 1;
      chk("ready_in_pend", 32'(hop_ready), 0);
      have = exp_q.size() != 0;
      if (!have) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_pkt: count %0d status %0d, required no descriptor",
                 pkt_hop_count, pkt_status);
      end else begin
        d = exp_q.pop_front();
        chk("pkt_count", 32'(pkt_hop_count), 32'(d.cnt));
        chk("pkt_status", 32'(pkt_status), 32'(d.st));
        chk("err_cnt", 32'(err_cnt), 32'(d.err));
        repeat ($urandom_range(0, 3)) @(negedge clk);
        for (int i = 0; i < d.cnt && i < MAXH; i++) begin
          hop_rd_addr = 4'(i);
          @(negedge clk);
          chk($sformatf("hop_rd[%0d]", i), 32'(hop_rd_data), 32'(d.hops[i]));
        end
        chk("count_hold", 32'(pkt_hop_count), 32'(d.cnt));
        chk("status_hold", 32'(pkt_status), 32'(d.st));
      end
      pkt_done = 1'b1;
      @(negedge clk);
      pkt_done = 1'b0;
      chk("valid_after_done", 32'(pkt_valid), 0);
      chk("ready_after_done", 32'(hop_ready), 1);
      mon_busy = 0;
    end
  end

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || mon_busy || pkt_valid) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d descriptors outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    int len, mid;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(hop_ready), 1);
    chk("rst_pkt_valid", 32'(pkt_valid), 0);
    chk("rst_count", 32'(pkt_hop_count), 0);
    chk("rst_status", 32'(pkt_status), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_rd_data", 32'(hop_rd_data), 0);
    rst = 1'b0;
    @(negedge clk);

    send(1, 0, 0, 16'hA0A0); send(0, 0, 0, 16'hB1B1); send(0, 1, 0, 16'hC2C2);
    drain();
    send(1, 1, 1, 16'h1234);
    drain();
    send_pkt(18, 0, -1);
    drain();
    send(0, 0, 0, 16'hDEAD);
    send_pkt(4, 0, 2);
    drain();
    send_pkt(3, 0, -1);
    send_pkt(5, 1, -1);
    drain();

    // Reset while collecting abandons the path.
    send(1, 0, 0, 16'h5555); send(0, 0, 0, 16'h6666);
    rst = 1'b1;
    #1;
    chk("midrst_pkt_valid", 32'(pkt_valid), 0);
    chk("midrst_ready", 32'(hop_ready), 1);
    chk("midrst_err_cnt", 32'(err_cnt), 0);
    in_pkt = 0; ovf = 0; merr = 0; cur.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(1, 1, 0, 16'h7777);
    drain();

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        send(0, 1'($urandom), 1'($urandom), 16'($urandom));
      end else begin
        len = $urandom_range(1, 20);
        mid = ($urandom_range(0, 9) == 0 && len > 2) ? $urandom_range(1, len - 1) : -1;
        send_pkt(len, $urandom_range(0, 3) == 0, mid);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    // Drive err_cnt into saturation with stray beats.
    for (int k = 0; k < 260; k++) send(0, 1'($urandom), 0, 16'($urandom));
    @(negedge clk);
    chk("err_cnt_sat", 32'(err_cnt), 32'(merr));
    send_pkt(2, 1, -1);
    drain();
    repeat (3) @(negedge clk);
    chk("final_err_cnt", 32'(err_cnt), 32'(merr));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pu_hop_rx.md
PU_HOP_RX -- requirements
Module: pu_hop_rx

Interface
REQ-001 SHALL have parameter HOP_NBITS, default `HOP_INFO_NBITS, width of one hop record.
REQ-002 SHALL have parameter MAX_HOPS, default 16, hop buffer depth (power of 2).
REQ-003 SHALL have parameter CNT_NBITS, default 5, hop-count width (log2(MAX_HOPS)+1).
REQ-004 SHALL have port clk input 1 -- single clock, all state on rising edge.
REQ-005 SHALL have port `RESET_SIG` input 1 -- asynchronous, active-high reset.
REQ-006 SHALL have port pp_pu_hop_valid input 1 -- hop beat offered.
REQ-007 SHALL have port pp_pu_hop_data input HOP_NBITS -- hop record.
REQ-008 SHALL have port pp_pu_hop_sop input 1 -- first hop of packet path.
REQ-009 SHALL have port pp_pu_hop_eop input 1 -- last hop of packet path.
REQ-010 SHALL have port pp_pu_hop_error input 1 -- upstream parse error, qualified on eop beat.
REQ-011 SHALL have port pu_pp_hop_ready output 1 -- beat accepted when valid&ready.
REQ-012 SHALL have port pkt_valid output 1 -- completed path descriptor available.
REQ-013 SHALL have port pkt_hop_count output CNT_NBITS -- hops stored (0..MAX_HOPS).
REQ-014 SHALL have port pkt_status output 2 -- 0 OK, 1 UPSTREAM_ERR, 2 OVERFLOW, 3 FRAMING.
REQ-015 SHALL have port pkt_done input 1 -- consumer releases descriptor and buffer.
REQ-016 SHALL have port hop_rd_addr input log2(MAX_HOPS) -- buffer read index.
REQ-017 SHALL have port hop_rd_data output HOP_NBITS -- registered read data, 1-cycle latency.
REQ-018 SHALL have port err_cnt output 8 -- saturating count of non-OK packets and stray beats.

Function
REQ-019 SHALL implement states IDLE, COLLECT, DROP, PEND; accept = pp_pu_hop_valid & pu_pp_hop_ready.
REQ-020 SHALL drive pu_pp_hop_ready=1 in IDLE/COLLECT/DROP, 0 in PEND (combinational from state only, never from valid).
REQ-021 IDLE: accepted sop&~eop SHALL write beat to addr 0, count=1, go COLLECT.
REQ-022 IDLE: accepted sop&eop SHALL write addr 0, count=1, status=error?1:0, go PEND.
REQ-023 IDLE: accepted beat without sop SHALL be discarded, err_cnt+1, stay IDLE.
REQ-024 COLLECT: accepted beat with count<MAX_HOPS SHALL write at addr=count, count+1.
REQ-025 COLLECT: eop beat SHALL be stored (if room) then go PEND; status 1 if pp_pu_hop_error else 0.
REQ-026 COLLECT: beat arriving with count==MAX_HOPS SHALL not be written; status:=2; go DROP (or PEND directly if that beat has eop).
REQ-027 COLLECT: accepted sop beat SHALL discard prior hops, restart at addr 0 with count=1, err_cnt+1, stay COLLECT (or PEND if also eop).
REQ-028 DROP: beats SHALL be consumed without write; eop beat SHALL go PEND with status 2 regardless of error flag, count held at MAX_HOPS.
REQ-029 PEND: pkt_valid SHALL be 1; pkt_hop_count and pkt_status SHALL be stable until pkt_done.
REQ-030 eop accepted in cycle N SHALL give pkt_valid=1 in cycle N+1.
REQ-031 pkt_done in PEND SHALL return to IDLE next cycle (pkt_valid=0, ready=1); pkt_done outside PEND SHALL be ignored.
REQ-032 Entering PEND with status!=0 SHALL increment err_cnt; err_cnt SHALL saturate at 255, never wrap.
REQ-033 hop_rd_data SHALL equal buffer[hop_rd_addr] sampled the previous cycle, in any state; buffer write and read same address same cycle SHALL return old data.
REQ-034 Buffer contents SHALL be written only on accepted beats; no write in PEND.

Reset
REQ-035 Reset SHALL force state IDLE, pu_pp_hop_ready=1, pkt_valid=0, pkt_hop_count=0, pkt_status=0, err_cnt=0, hop_rd_data=0.
REQ-036 Reset asserted mid-packet (COLLECT/DROP/PEND) SHALL abandon the packet; buffer contents need not be cleared.

Verification
REQ-037 3-hop packet A,B,C (sop on A, eop on C), no error -> pkt_valid cycle after C, count=3, status=0, reads addr 0..2 return A,B,C.
REQ-038 Single beat sop&eop&error=1 -> count=1, status=1, err_cnt=1; pkt_done -> ready=1 next cycle.
REQ-039 18-hop packet with MAX_HOPS=16 -> first 16 stored, status=2, count=16, ready held 1 until eop, err_cnt+1.
REQ-040 Stray non-sop beat in IDLE, then sop mid-packet after 2 hops -> err_cnt=2, final descriptor holds only the new packet's hops.
REQ-041 Second packet valid while PEND -> ready=0, no beats lost; after pkt_done second packet received intact with correct count.
REQ-042 Reset asserted in COLLECT after 2 hops -> immediately IDLE, pkt_valid=0, following 1-hop packet gives count=1, status=0.
